// File: rtl/net_tx_arbiter_pkg.sv
// Shared AXI-Stream widths, arbiter FSM states and the beat record used by the output register.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package net_tx_arbiter_pkg;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int USER_W = 64;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } state_t;

    // One stream beat as it sits in the output register.
    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [KEEP_W-1:0] tkeep;
        logic [USER_W-1:0] tuser;
        logic              tlast;
    } beat_t;

    // Width of a source id for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/net_tx_arbiter_if.sv
// Bundle of the per-port request streams, the merged output stream and the status of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: s_axis_tready / m_axis_tready carry the valid-ready handshake in each direction.
interface net_tx_arbiter_if
    import net_tx_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ID_W      = id_width(NUM_PORTS),
    parameter int CNT_W     = 16
) ();

    logic [NUM_PORTS-1:0]        port_en;

    logic [NUM_PORTS*DATA_W-1:0] s_axis_tdata;
    logic [NUM_PORTS*KEEP_W-1:0] s_axis_tkeep;
    logic [NUM_PORTS*USER_W-1:0] s_axis_tuser;
    logic [NUM_PORTS-1:0]        s_axis_tlast;
    logic [NUM_PORTS-1:0]        s_axis_tvalid;
    logic [NUM_PORTS-1:0]        s_axis_tready;

    logic [DATA_W-1:0]           m_axis_tdata;
    logic [KEEP_W-1:0]           m_axis_tkeep;
    logic [USER_W-1:0]           m_axis_tuser;
    logic                        m_axis_tlast;
    logic [ID_W-1:0]             m_axis_tdest;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;

    logic                        busy;
    logic [NUM_PORTS*CNT_W-1:0]  pkt_cnt;

    // Arbiter side: consumes the request streams, masters the merged stream and status.
    modport master (
        input  port_en,
        input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tdest, m_axis_tvalid,
        input  m_axis_tready,
        output busy, pkt_cnt
    );

    // Surrounding logic: produces the request streams and sinks the merged stream.
    modport slave (
        output port_en,
        output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tdest, m_axis_tvalid,
        output m_axis_tready,
        input  busy, pkt_cnt
    );

endinterface

// File: rtl/net_tx_arbiter_rr_arbiter.sv
// Rotate-priority request picker: first set req bit searching upward from last_grant+1 with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the returned grant is taken.
module net_tx_arbiter_rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ID_W      = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_W-1:0]      last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [ID_W-1:0]      grant_id,
    output logic                 any_req
);

    int                   idx;
    logic [NUM_PORTS-1:0] req_rot;

    // Walk candidates from farthest to nearest so the nearest requester overwrites the rest.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        idx      = 0;
        req_rot  = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            req_rot = req >> idx;
            if (req_rot[0]) begin
                grant    = NUM_PORTS'(1) << idx;
                grant_id = ID_W'(idx);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/net_tx_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS AXI-Stream requesters onto one registered output stream.
// Latency: 1 arbitration cycle, then 1 registered cycle per beat; 1 bubble between packets.
// Backpressure: granted port sees ~m_axis_tvalid | m_axis_tready; all other ports are held off.
module net_tx_arbiter
    import net_tx_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ID_W      = id_width(NUM_PORTS),
    parameter int CNT_W     = 16
) (
    input  logic            apclk,
    input  logic            apresetn,
    net_tx_arbiter_if.master bus
);

    state_t               state_q, state_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic [ID_W-1:0]      last_grant_q, last_grant_d;
    logic [NUM_PORTS-1:0] grant_oh_q, grant_oh_d;

    beat_t                m_beat_q, m_beat_d;
    logic [ID_W-1:0]      m_dest_q, m_dest_d;
    logic                 m_vld_q, m_vld_d;

    logic [CNT_W-1:0]     pkt_cnt_q [NUM_PORTS];
    logic [CNT_W-1:0]     pkt_cnt_d [NUM_PORTS];

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] arb_grant;
    logic [ID_W-1:0]      arb_id;
    logic                 arb_any;

    logic                 out_rdy;
    logic                 sel_vld;
    logic                 ld;
    beat_t                s_beat;

    // Only enabled, valid ports compete; port_en is irrelevant once a packet is under way.
    assign req = bus.s_axis_tvalid & bus.port_en;

    net_tx_arbiter_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .ID_W      (ID_W)
    ) u_rr (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_id   (arb_id),
        .any_req    (arb_any)
    );

    // Output register can take a beat when empty or draining this cycle.
    assign out_rdy = ~m_vld_q | bus.m_axis_tready;

    // Mux of the granted port's beat; no path from here to m_axis except through the register.
    assign s_beat.tdata = bus.s_axis_tdata[grant_id_q*DATA_W +: DATA_W];
    assign s_beat.tkeep = bus.s_axis_tkeep[grant_id_q*KEEP_W +: KEEP_W];
    assign s_beat.tuser = bus.s_axis_tuser[grant_id_q*USER_W +: USER_W];
    assign s_beat.tlast = bus.s_axis_tlast[grant_id_q];
    assign sel_vld      = bus.s_axis_tvalid[grant_id_q];

    assign ld = (state_q == XFER) && sel_vld && out_rdy;

    // Ready is steered to the owner only, and only while a packet is being transferred.
    assign bus.s_axis_tready = grant_oh_q & {NUM_PORTS{(state_q == XFER) && out_rdy}};

    // Next-state: arbitration, output register load/drain and per-port packet counting.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        grant_oh_d   = grant_oh_q;
        m_beat_d     = m_beat_q;
        m_dest_d     = m_dest_q;
        m_vld_d      = m_vld_q;
        pkt_cnt_d    = pkt_cnt_q;

        if (m_vld_q && bus.m_axis_tready) begin
            m_vld_d = 1'b0;
        end

        case (state_q)
            ARB: begin
                if (arb_any) begin
                    grant_id_d   = arb_id;
                    last_grant_d = arb_id;
                    grant_oh_d   = arb_grant;
                    state_d      = XFER;
                end
            end
            XFER: begin
                if (ld) begin
                    m_beat_d = s_beat;
                    m_dest_d = grant_id_q;
                    m_vld_d  = 1'b1;
                    if (s_beat.tlast) begin
                        pkt_cnt_d[grant_id_q] = pkt_cnt_q[grant_id_q] + CNT_W'(1);
                        state_d               = ARB;
                    end
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // State and output registers; reset drops any packet in flight and gives port 0 first priority.
    always_ff @(posedge apclk or negedge apresetn) begin
        if (!apresetn) begin
            state_q      <= ARB;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(NUM_PORTS - 1);
            grant_oh_q   <= '0;
            m_beat_q     <= '0;
            m_dest_q     <= '0;
            m_vld_q      <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                pkt_cnt_q[p] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            grant_oh_q   <= grant_oh_d;
            m_beat_q     <= m_beat_d;
            m_dest_q     <= m_dest_d;
            m_vld_q      <= m_vld_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign bus.m_axis_tdata  = m_beat_q.tdata;
    assign bus.m_axis_tkeep  = m_beat_q.tkeep;
    assign bus.m_axis_tuser  = m_beat_q.tuser;
    assign bus.m_axis_tlast  = m_beat_q.tlast;
    assign bus.m_axis_tdest  = m_dest_q;
    assign bus.m_axis_tvalid = m_vld_q;
    assign bus.busy          = (state_q == XFER);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
        assign bus.pkt_cnt[p*CNT_W +: CNT_W] = pkt_cnt_q[p];
    end

endmodule

// File: tb/tb_net_tx_arbiter.sv
// Directed bench for net_tx_arbiter: single packet, fairness, backpressure, enables, reset, wrap.
// Latency: expectations use cycle 0 = first cycle a request is visible in ARB.
// Backpressure: m_axis_tready driven from per-test tables.
module tb_net_tx_arbiter;

    localparam int NP    = 4;
    localparam int IDW   = 2;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [IDW-1:0] dest;
        logic           last;
        logic [63:0]    data;
    } rec_t;

    logic apclk;
    logic apresetn;

    net_tx_arbiter_if #(.NUM_PORTS(NP), .ID_W(IDW), .CNT_W(CNT_W)) bus ();

    net_tx_arbiter #(.NUM_PORTS(NP), .ID_W(IDW), .CNT_W(CNT_W)) dut (
        .apclk    (apclk),
        .apresetn (apresetn),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    // Source model state: packets remaining, length, current beat/packet, data base.
    int          src_npkt [NP];
    int          src_len  [NP];
    int          src_beat [NP];
    int          src_pkt  [NP];
    logic [63:0] src_base [NP];
    logic [NP-1:0] hs_s;
    rec_t        mon_q [$];

    initial begin
        apclk = 1'b0;
        forever #5 apclk = ~apclk;
    end

    // Capture handshakes and accepted output beats away from the active edge.
    always @(negedge apclk) begin
        hs_s = bus.s_axis_tvalid & bus.s_axis_tready;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            mon_q.push_back({bus.m_axis_tdest, bus.m_axis_tlast, bus.m_axis_tdata});
        end
    end

    // Advance each source on its handshake, then present its next beat.
    always @(posedge apclk) begin
        #2;
        for (int p = 0; p < NP; p++) begin
            if (hs_s[p] && src_npkt[p] > 0) begin
                if (src_beat[p] == src_len[p] - 1) begin
                    src_beat[p] = 0;
                    src_pkt[p]  = src_pkt[p] + 1;
                    src_npkt[p] = src_npkt[p] - 1;
                end else begin
                    src_beat[p] = src_beat[p] + 1;
                end
            end
        end
        hs_s = '0;
        for (int p = 0; p < NP; p++) begin
            logic [63:0] d;
            logic        l;
            d = src_base[p] + (64'(src_pkt[p]) << 8) + 64'(src_beat[p]);
            l = (src_beat[p] == src_len[p] - 1);
            bus.s_axis_tvalid[p]         = (src_npkt[p] > 0);
            bus.s_axis_tdata[p*64 +: 64] = d;
            bus.s_axis_tuser[p*64 +: 64] = ~d;
            bus.s_axis_tkeep[p*8 +: 8]   = l ? 8'h0F : 8'hFF;
            bus.s_axis_tlast[p]          = l;
        end
    end

    task automatic clear_sources();
        for (int p = 0; p < NP; p++) begin
            src_npkt[p] = 0;
            src_len[p]  = 1;
            src_beat[p] = 0;
            src_pkt[p]  = 0;
            src_base[p] = 64'(p + 1) << 32;
        end
    endtask

    task automatic do_reset();
        @(posedge apclk); #1;
        apresetn          = 1'b0;
        bus.m_axis_tready = 1'b1;
        bus.port_en       = 4'hF;
        repeat (2) @(posedge apclk);
        #1;
        clear_sources();
        mon_q.delete();
        @(posedge apclk); #1;
        apresetn = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge apclk);
        checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got=%0b exp=0", bus.m_axis_tvalid); end
        checks++; if (bus.m_axis_tdata !== 64'h0) begin errors++; $display("FAIL rst_tdata got=%h exp=0", bus.m_axis_tdata); end
        checks++; if (bus.m_axis_tuser !== 64'h0 || bus.m_axis_tkeep !== 8'h0) begin errors++; $display("FAIL rst_tuser_tkeep got=%h/%h exp=0/0", bus.m_axis_tuser, bus.m_axis_tkeep); end
        checks++; if (bus.m_axis_tlast !== 1'b0 || bus.m_axis_tdest !== 2'd0) begin errors++; $display("FAIL rst_tlast_tdest got=%0b/%0d exp=0/0", bus.m_axis_tlast, bus.m_axis_tdest); end
        checks++; if (bus.s_axis_tready !== 4'b0000) begin errors++; $display("FAIL rst_s_tready got=%b exp=0000", bus.s_axis_tready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.pkt_cnt !== 16'h0) begin errors++; $display("FAIL rst_pkt_cnt got=%h exp=0", bus.pkt_cnt); end
    endtask

    task automatic test_single();
        do_reset();
        @(posedge apclk); #1;
        src_base[2] = 64'hA0; src_len[2] = 3; src_npkt[2] = 1;
        @(negedge apclk); // cycle 0
        checks++; if (bus.s_axis_tready !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_c0 got rdy=%b busy=%0b exp rdy=0000 busy=0", bus.s_axis_tready, bus.busy); end
        @(negedge apclk); // cycle 1
        checks++; if (bus.s_axis_tready !== 4'b0100 || bus.busy !== 1'b1 || bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_c1 got rdy=%b busy=%0b vld=%0b exp rdy=0100 busy=1 vld=0", bus.s_axis_tready, bus.busy, bus.m_axis_tvalid); end
        @(negedge apclk); // cycle 2
        checks++; if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 64'hA0 || bus.m_axis_tdest !== 2'd2 || bus.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL single_beat0 got vld=%0b d=%h dest=%0d last=%0b exp 1/a0/2/0", bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tdest, bus.m_axis_tlast); end
        checks++; if (bus.m_axis_tkeep !== 8'hFF || bus.m_axis_tuser !== ~64'hA0) begin errors++; $display("FAIL single_keep_user got keep=%h user=%h exp ff/%h", bus.m_axis_tkeep, bus.m_axis_tuser, ~64'hA0); end
        @(negedge apclk); // cycle 3
        checks++; if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 64'hA1 || bus.m_axis_tdest !== 2'd2) begin errors++; $display("FAIL single_beat1 got vld=%0b d=%h dest=%0d exp 1/a1/2", bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tdest); end
        @(negedge apclk); // cycle 4
        checks++; if (bus.m_axis_tdata !== 64'hA2 || bus.m_axis_tlast !== 1'b1 || bus.m_axis_tkeep !== 8'h0F || bus.m_axis_tdest !== 2'd2) begin errors++; $display("FAIL single_beat2 got d=%h last=%0b keep=%h dest=%0d exp a2/1/0f/2", bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdest); end
        checks++; if (bus.busy !== 1'b0 || bus.pkt_cnt[2*CNT_W +: CNT_W] !== 4'd1) begin errors++; $display("FAIL single_done got busy=%0b cnt2=%0d exp 0/1", bus.busy, bus.pkt_cnt[2*CNT_W +: CNT_W]); end
        @(negedge apclk); // cycle 5
        checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_drain got vld=%0b exp 0", bus.m_axis_tvalid); end
    endtask

    task automatic test_fairness();
        int n;
        do_reset();
        @(posedge apclk); #1;
        for (int p = 0; p < NP; p++) begin
            src_len[p] = 2; src_npkt[p] = 10;
        end
        n = 0;
        while (mon_q.size() < 80 && n < 600) begin @(negedge apclk); n++; end
        checks++; if (mon_q.size() != 80) begin errors++; $display("FAIL fair_count got=%0d exp=80", mon_q.size()); end
        for (int k = 0; k < 80; k++) begin
            rec_t exp_r;
            int   dst;
            dst        = (k / 2) % 4;
            exp_r.dest = IDW'(dst);
            exp_r.last = (k % 2) == 1;
            exp_r.data = src_base[dst] + (64'(k / 8) << 8) + 64'(k % 2);
            checks++;
            if (mon_q[k] !== exp_r) begin errors++; $display("FAIL fair_beat%0d got dest=%0d last=%0b d=%h exp dest=%0d last=%0b d=%h", k, mon_q[k].dest, mon_q[k].last, mon_q[k].data, exp_r.dest, exp_r.last, exp_r.data); end
        end
        for (int p = 0; p < NP; p++) begin
            checks++; if (bus.pkt_cnt[p*CNT_W +: CNT_W] !== 4'd10) begin errors++; $display("FAIL fair_cnt%0d got=%0d exp=10", p, bus.pkt_cnt[p*CNT_W +: CNT_W]); end
        end
    endtask

    task automatic test_backpressure();
        logic        r_tab   [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        logic        exp_rdy [10] = '{0, 1, 1, 0, 0, 1, 1, 1, 0, 0};
        logic        exp_vld [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [63:0] exp_dat [10] = '{0, 0, 64'h100, 64'h101, 64'h101, 64'h101, 64'h102, 64'h103, 64'h104, 0};
        do_reset();
        @(posedge apclk); #1;
        src_base[0] = 64'h100; src_len[0] = 5; src_npkt[0] = 1;
        for (int c = 0; c < 10; c++) begin
            bus.m_axis_tready = r_tab[c];
            @(negedge apclk);
            checks++; if (bus.s_axis_tready[0] !== exp_rdy[c] || bus.m_axis_tvalid !== exp_vld[c]) begin errors++; $display("FAIL bp_c%0d got rdy=%0b vld=%0b exp rdy=%0b vld=%0b", c, bus.s_axis_tready[0], bus.m_axis_tvalid, exp_rdy[c], exp_vld[c]); end
            if (exp_vld[c]) begin
                checks++; if (bus.m_axis_tdata !== exp_dat[c]) begin errors++; $display("FAIL bp_data_c%0d got=%h exp=%h", c, bus.m_axis_tdata, exp_dat[c]); end
            end
            @(posedge apclk); #1;
        end
        checks++; if (mon_q.size() != 5) begin errors++; $display("FAIL bp_beats got=%0d exp=5", mon_q.size()); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (mon_q[k].data !== 64'h100 + 64'(k) || mon_q[k].last !== (k == 4)) begin errors++; $display("FAIL bp_seq%0d got d=%h last=%0b exp d=%h last=%0b", k, mon_q[k].data, mon_q[k].last, 64'h100 + 64'(k), (k == 4)); end
        end
    endtask

    task automatic test_enable();
        int pk_dest [8] = '{0, 1, 3, 0, 3, 0, 3, 0};
        int pk_num  [8] = '{0, 0, 0, 1, 1, 2, 2, 3};
        int n;
        do_reset();
        @(posedge apclk); #1;
        bus.port_en = 4'b1011;
        for (int p = 0; p < NP; p++) begin
            src_len[p] = 3; src_npkt[p] = 10;
        end
        repeat (6) @(posedge apclk);
        #1;
        bus.port_en = 4'b1001;  // port 1 is mid-packet here
        n = 0;
        while (mon_q.size() < 24 && n < 300) begin @(negedge apclk); n++; end
        checks++; if (mon_q.size() < 24) begin errors++; $display("FAIL en_count got=%0d exp>=24", mon_q.size()); end
        for (int k = 0; k < 24; k++) begin
            rec_t exp_r;
            int   j;
            j          = k / 3;
            exp_r.dest = IDW'(pk_dest[j]);
            exp_r.last = (k % 3) == 2;
            exp_r.data = src_base[pk_dest[j]] + (64'(pk_num[j]) << 8) + 64'(k % 3);
            checks++;
            if (mon_q[k] !== exp_r) begin errors++; $display("FAIL en_beat%0d got dest=%0d last=%0b d=%h exp dest=%0d last=%0b d=%h", k, mon_q[k].dest, mon_q[k].last, mon_q[k].data, exp_r.dest, exp_r.last, exp_r.data); end
        end
        checks++; if (bus.pkt_cnt[1*CNT_W +: CNT_W] !== 4'd1 || bus.pkt_cnt[2*CNT_W +: CNT_W] !== 4'd0) begin errors++; $display("FAIL en_cnt got cnt1=%0d cnt2=%0d exp 1/0", bus.pkt_cnt[1*CNT_W +: CNT_W], bus.pkt_cnt[2*CNT_W +: CNT_W]); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        @(posedge apclk); #1;
        src_base[3] = 64'h300; src_len[3] = 4; src_npkt[3] = 1;
        repeat (4) @(negedge apclk); // cycle 3: beat 2 of 4 on the output
        checks++; if (bus.m_axis_tdata !== 64'h301 || bus.busy !== 1'b1) begin errors++; $display("FAIL rmid_pre got d=%h busy=%0b exp 301/1", bus.m_axis_tdata, bus.busy); end
        #2;
        apresetn = 1'b0;
        #1;
        checks++; if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tdata !== 64'h0 || bus.m_axis_tdest !== 2'd0) begin errors++; $display("FAIL rmid_async_m got vld=%0b d=%h dest=%0d exp 0/0/0", bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tdest); end
        checks++; if (bus.s_axis_tready !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_async_ctl got rdy=%b busy=%0b exp 0000/0", bus.s_axis_tready, bus.busy); end
        @(posedge apclk); #1;
        clear_sources();
        mon_q.delete();
        @(posedge apclk); #1;
        apresetn = 1'b1;
        src_base[0] = 64'hAA;  src_len[0] = 1; src_npkt[0] = 1;
        src_base[3] = 64'h3AA; src_len[3] = 1; src_npkt[3] = 1;
        n = 0;
        while (mon_q.size() < 2 && n < 50) begin @(negedge apclk); n++; end
        checks++; if (mon_q[0].dest !== 2'd0 || mon_q[0].data !== 64'hAA) begin errors++; $display("FAIL rmid_first got dest=%0d d=%h exp 0/aa", mon_q[0].dest, mon_q[0].data); end
        checks++; if (mon_q[1].dest !== 2'd3 || mon_q[1].data !== 64'h3AA) begin errors++; $display("FAIL rmid_second got dest=%0d d=%h exp 3/3aa", mon_q[1].dest, mon_q[1].data); end
        checks++; if (bus.pkt_cnt[3*CNT_W +: CNT_W] !== 4'd1) begin errors++; $display("FAIL rmid_cnt3 got=%0d exp=1", bus.pkt_cnt[3*CNT_W +: CNT_W]); end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        @(posedge apclk); #1;
        src_base[1] = 64'h1000; src_len[1] = 1; src_npkt[1] = 17;
        n = 0;
        while (mon_q.size() < 16 && n < 200) begin @(negedge apclk); n++; end
        checks++; if (bus.pkt_cnt[1*CNT_W +: CNT_W] !== 4'd0 || mon_q.size() != 16) begin errors++; $display("FAIL wrap16 got cnt=%0d beats=%0d exp 0/16", bus.pkt_cnt[1*CNT_W +: CNT_W], mon_q.size()); end
        n = 0;
        while (mon_q.size() < 17 && n < 50) begin @(negedge apclk); n++; end
        repeat (3) @(negedge apclk);
        checks++; if (bus.pkt_cnt[1*CNT_W +: CNT_W] !== 4'd1 || mon_q.size() != 17) begin errors++; $display("FAIL wrap17 got cnt=%0d beats=%0d exp 1/17", bus.pkt_cnt[1*CNT_W +: CNT_W], mon_q.size()); end
        checks++; if (mon_q[16].data !== 64'h1000 + (64'd16 << 8) || mon_q[16].dest !== 2'd1) begin errors++; $display("FAIL wrap_last got d=%h dest=%0d exp %h/1", mon_q[16].data, mon_q[16].dest, 64'h1000 + (64'd16 << 8)); end
    endtask

    initial begin
        apresetn          = 1'b0;
        bus.m_axis_tready = 1'b1;
        bus.port_en       = 4'hF;
        hs_s              = '0;
        clear_sources();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/net_tx_arbiter.md
# net_tx_arbiter

Packet-atomic round-robin arbiter that merges up to NUM_PORTS application reply streams (64-bit AXI-Stream) into the single app-to-network stream feeding the header handler's fromApp port. Once a port wins, it owns the output until its tlast beat is accepted, so packets never interleave. The output is registered for timing. Per-port enables and packet counters let software drain or idle a requester without disturbing traffic already in flight.

## Interface
- NUM_PORTS, default 4: number of requesting streams (2..8).
- ID_W, default 2: width of source id, $clog2(NUM_PORTS), minimum 1.
- CNT_W, default 16: width of each per-port packet counter.

- apclk  in  1  sole clock; all logic on rising edge.
- apresetn  in  1  reset, asynchronous assert, active-low.
- port_en  in  NUM_PORTS  per-port arbitration enable; sampled only in ARB.
- s_axis_tdata  in  NUM_PORTS*64  port p at [p*64 +: 64].
- s_axis_tkeep  in  NUM_PORTS*8  port p at [p*8 +: 8].
- s_axis_tuser  in  NUM_PORTS*64  port p at [p*64 +: 64].
- s_axis_tlast  in  NUM_PORTS  end of packet.
- s_axis_tvalid  in  NUM_PORTS  beat valid.
- s_axis_tready  out  NUM_PORTS  beat accepted when tvalid&tready.
- m_axis_tdata / tkeep / tuser / tlast  out  64/8/64/1  merged stream.
- m_axis_tdest  out  ID_W  source port of current beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high in XFER state.
- pkt_cnt  out  NUM_PORTS*CNT_W  packets forwarded per port, wraps at 2^CNT_W.

## Operation
- States: ARB, XFER.
- ARB: req = s_axis_tvalid & port_en. If req≠0, pick the first set bit searching from (last_grant+1) mod NUM_PORTS upward with wrap. Register grant_id and last_grant, then go to XFER. If req=0, stay. All s_axis_tready are low in ARB.
- XFER: s_axis_tready[grant_id] = ~m_axis_tvalid | m_axis_tready. All other readies are 0.
  - Each accepted beat loads the output register: data, keep, user, last, and tdest = grant_id.
  - An accepted beat with tlast=1 increments pkt_cnt[grant_id] and returns to ARB.
- Output register: m_axis_tvalid sets on load. It clears when m_axis_tready is high and no new beat loads in the same cycle. Data is held stable while tvalid&~tready.
- port_en deassertion mid-packet does not abort the packet. It takes effect at the next ARB.
- A granted port that drops tvalid mid-packet stalls the arbiter in XFER. There is no timeout.
- Simultaneous output drain and load: the new beat replaces the old one and tvalid stays 1.
- Reset at any time, including mid-packet:
  - State goes to ARB, last_grant to NUM_PORTS-1 (so port 0 has first priority), grant_id to 0.
  - Outputs go to 0: m_axis_* all zero, s_axis_tready all zero, busy 0, pkt_cnt all zero.
  - A partially sent packet is discarded. The downstream side sees a truncated packet with no tlast.

## Timing
- Arbitration costs 1 cycle.
- Port p tvalid first seen in ARB at cycle 0:
  - grant registered at the cycle 0 edge;
  - s_axis_tready[p] high in cycle 1;
  - first beat on m_axis in cycle 2.
- Steady-state throughput is 1 beat/cycle while m_axis_tready=1.
- There is exactly 1 bubble cycle between back-to-back packets: the tlast output cycle is followed by the ARB cycle.
- Ready to the granted port is combinational from m_axis_tready. There is no combinational path from s_axis_tvalid to any m_axis output.

## Structure
- Shared package (axis_pkg): DATA_W=64, KEEP_W=8, USER_W=64 constants, and the state enum {ARB, XFER}.
- Sub-module rr_arbiter: inputs req and last_grant; outputs grant one-hot, grant_id and any_req. It is pure combinational rotate-priority logic, reused by other multi-requester blocks.
- Top level holds the FSM, the output register, the ready steering and the counters.

## Test plan
- Single packet: port 2 sends 3 beats (tdata 0xA0..0xA2, last on the 3rd) with m_axis_tready=1 → m_axis shows the 3 beats in cycles 2..4, tdest=2 on each, pkt_cnt[2]=1, busy falls after the last beat.
- Fairness: all 4 ports continuously send 2-beat packets → grant order is 0,1,2,3,0,1,… with no interleaving inside any packet; each port gets 25% of packets over 40 packets.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 5-beat packet → each beat is held stable while stalled, no beat is lost or duplicated, and s_axis_tready follows the rule ~m_axis_tvalid|m_axis_tready.
- Enable mask: port_en=4'b1011 with all ports valid → port 2 is never granted; clearing port_en[1] mid-packet lets port 1 finish its packet, and port 1 is not granted afterwards.
- Reset mid-packet: apresetn asserted during beat 2 of 4 → all outputs go to 0 immediately (asynchronously); after release the first grant goes to port 0 when ports 0 and 3 are both valid.
- Counter wrap: with CNT_W=4, port 1 sends 17 single-beat packets → pkt_cnt[1]=1.
